// File: rtl/axi4_lite_slave_regfile.sv
// axi4_lite_slave_regfile: AXI4-Lite slave with NUM_REGS x 32-bit registers; define AXI4_LITE_SLAVE_SLVERR_EN for SLVERR on out-of-range accesses
module axi4_lite_slave_regfile #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [ADDR_WIDTH-1:0]    AWADDR,
    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [1:0]               BRESP,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    input  logic [ADDR_WIDTH-1:0]    ARADDR,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic [NUM_REGS*32-1:0]   USR_REGS,
    output logic [NUM_REGS-1:0]      USR_WR
);
    localparam int IW = ADDR_WIDTH - 2;
`ifdef AXI4_LITE_SLAVE_SLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    w_state_e                   w_state_q, w_state_d;
    r_state_e                   r_state_q, r_state_d;
    logic                       awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]                 bresp_q, bresp_d, rresp_q, rresp_d;
    logic [IW-1:0]              waddr_q, waddr_d;
    logic [31:0]                wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]                 wstrb_q, wstrb_d;
    logic [NUM_REGS-1:0][31:0]  regs_q, regs_d;
    logic [NUM_REGS-1:0]        usr_wr_q, usr_wr_d;
    logic                       arready_q, arready_d, rvalid_q, rvalid_d;
    logic                       aw_hs, w_hs, ar_hs, commit, w_hit, r_hit, unused_addr_lsbs;
    logic [IW-1:0]              w_idx, r_idx;
    logic [31:0]                c_data, rd_val;
    logic [3:0]                 c_strb;

    assign aw_hs            = AWVALID && awready_q;
    assign w_hs             = WVALID && wready_q;
    assign ar_hs            = ARVALID && arready_q;
    assign commit           = (w_state_q == W_IDLE && aw_hs && w_hs) ||
                              (w_state_q == W_HAVE_ADDR && w_hs) ||
                              (w_state_q == W_HAVE_DATA && aw_hs);
    assign w_idx            = (w_state_q == W_HAVE_ADDR) ? waddr_q : AWADDR[ADDR_WIDTH-1:2];
    assign c_data           = (w_state_q == W_HAVE_DATA) ? wdata_q : WDATA;
    assign c_strb           = (w_state_q == W_HAVE_DATA) ? wstrb_q : WSTRB;
    assign r_idx            = ARADDR[ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

    // address decode: range hits and the read mux (out-of-range reads yield 0)
    always_comb begin
        w_hit  = 1'b0;
        r_hit  = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == IW'(i)) w_hit = 1'b1;
            if (r_idx == IW'(i)) begin
                r_hit  = 1'b1;
                rd_val = regs_q[i];
            end
        end
    end

    // byte-lane register update and write pulse on a completed write
    always_comb begin
        regs_d   = regs_q;
        usr_wr_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && w_idx == IW'(i)) begin
                usr_wr_d[i] = |c_strb;
                for (int b = 0; b < 4; b++)
                    if (c_strb[b]) regs_d[i][8*b +: 8] = c_data[8*b +: 8];
            end
        end
    end

    // write channel FSM: gather AW and W in either order, then hold B until accepted
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                wready_d  = 1'b1;
                if (aw_hs && !w_hs) begin
                    w_state_d = W_HAVE_ADDR;
                    waddr_d   = AWADDR[ADDR_WIDTH-1:2];
                    awready_d = 1'b0;
                end
                if (w_hs && !aw_hs) begin
                    w_state_d = W_HAVE_DATA;
                    wdata_d   = WDATA;
                    wstrb_d   = WSTRB;
                    wready_d  = 1'b0;
                end
            end
            W_HAVE_ADDR, W_HAVE_DATA: ;
            W_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
        endcase
        if (commit) begin
            w_state_d = W_RESP;
            awready_d = 1'b0;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_hit ? 2'b00 : ERR_RESP;
        end
    end

    // read channel FSM: capture data at AR handshake, hold until R accepted
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    r_state_d = R_RESP;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_val;
                    rresp_d   = r_hit ? 2'b00 : ERR_RESP;
                end
            end
            R_RESP: begin
                if (RREADY) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            regs_q    <= '0;
            usr_wr_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            regs_q    <= regs_d;
            usr_wr_q  <= usr_wr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign AWREADY  = awready_q;
    assign WREADY   = wready_q;
    assign BVALID   = bvalid_q;
    assign BRESP    = bresp_q;
    assign ARREADY  = arready_q;
    assign RVALID   = rvalid_q;
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;
    assign USR_REGS = regs_q;
    assign USR_WR   = usr_wr_q;
endmodule
